// File: rtl/pcileech_com_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the FT601 TX word stream.
// A grant is held from first word to 'last'; a grant whose source stalls mid-packet is released.
//
// state | meaning
// IDLE  | no grant held; picks the next requester round-robin (one bubble per packet)
// BUSY  | grant locked to one source until its last word is accepted or the timer expires

module pcileech_com_tx_arbiter #(
  parameter int N_SRC          = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [32*N_SRC-1:0]  src_data,
  input  logic [N_SRC-1:0]     src_last,
  input  logic [N_SRC-1:0]     src_valid,
  output logic [N_SRC-1:0]     src_ready,
  output logic [31:0]          dout,
  output logic [1:0]           dout_tag,
  output logic                 dout_last,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 abort_pulse,
  output logic [15:0]          abort_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic [1:0]     rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [31:0]    dout_q, dout_d;
  logic [1:0]     dout_tag_q, dout_tag_d;
  logic           dout_last_q, dout_last_d;
  logic           dout_valid_q, dout_valid_d;
  logic           abort_q, abort_d;
  logic [15:0]    abort_count_q, abort_count_d;

  // Requester vectors padded to the full 2-bit index space so grant can index them directly.
  logic [3:0]        valid_pad;
  logic [3:0]        last_pad;
  logic [3:0][31:0]  data_pad;
  logic [3:0]        ready_pad;

  logic [2:0]  cand;
  logic [1:0]  pick;
  logic        any_valid;
  logic [1:0]  next_ptr;
  logic        accept;

  always_comb begin
    valid_pad              = '0;
    last_pad               = '0;
    data_pad               = '0;
    valid_pad[N_SRC-1:0]   = src_valid;
    last_pad[N_SRC-1:0]    = src_last;
    data_pad[N_SRC-1:0]    = src_data;
  end

  // Walk offsets from farthest to nearest so the first valid source after rr_ptr wins.
  always_comb begin
    pick      = rr_ptr_q;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(N_SRC)) cand = cand - 3'(N_SRC);
      if (valid_pad[cand[1:0]]) begin
        pick      = cand[1:0];
        any_valid = 1'b1;
      end
    end
  end

  assign next_ptr = (grant_q == 2'(N_SRC - 1)) ? 2'd0 : grant_q + 2'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      dout_q        <= '0;
      dout_tag_q    <= '0;
      dout_last_q   <= 1'b0;
      dout_valid_q  <= 1'b0;
      abort_q       <= 1'b0;
      abort_count_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      timer_q       <= timer_d;
      dout_q        <= dout_d;
      dout_tag_q    <= dout_tag_d;
      dout_last_q   <= dout_last_d;
      dout_valid_q  <= dout_valid_d;
      abort_q       <= abort_d;
      abort_count_q <= abort_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = timer_q;
    abort_d       = 1'b0;
    abort_count_d = abort_count_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          timer_d = TIMER_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          timer_d = TIMER_LOAD;
          if (last_pad[grant_q]) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!valid_pad[grant_q]) begin
          // Only an absent word counts toward the timeout; backpressure never does.
          if (timer_q == '0) begin
            abort_d  = 1'b1;
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
            if (abort_count_q != 16'hFFFF) abort_count_d = abort_count_q + 16'd1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshake and output register
  always_comb begin
    ready_pad = '0;
    if (rst_n && state_q == BUSY) ready_pad[grant_q] = ~dout_valid_q | dout_ready;
    src_ready = ready_pad[N_SRC-1:0];
    accept    = (state_q == BUSY) && valid_pad[grant_q] && ready_pad[grant_q];

    dout_d       = dout_q;
    dout_tag_d   = dout_tag_q;
    dout_last_d  = dout_last_q;
    dout_valid_d = dout_valid_q;
    if (accept) begin
      dout_d       = data_pad[grant_q];
      dout_tag_d   = grant_q;
      dout_last_d  = last_pad[grant_q];
      dout_valid_d = 1'b1;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  assign dout        = dout_q;
  assign dout_tag    = dout_tag_q;
  assign dout_last   = dout_last_q;
  assign dout_valid  = dout_valid_q;
  assign abort_pulse = abort_q;
  assign abort_count = abort_count_q;

  a_grant_range: assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, grant_q} < 3'(N_SRC));

  a_hold_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (dout_valid_q && !dout_ready) |=>
      (!rst_n || (dout_valid_q && $stable({dout_q, dout_tag_q, dout_last_q}))));

endmodule
